// File: rtl/bcd_diff_display.sv
// Collects a digit-serial BCD difference (LSD first) and scans the committed result onto an active-low 7-seg display.
// Optional macro BCD_DISP_LZB_EN enables leading-zero blanking of digit positions DIGITS-1..1.
module bcd_diff_display #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      diff,
  input  logic            cout,
  input  logic            in_last,
  output logic [DIGITS:0] an,
  output logic [6:0]      seg,
  output logic            neg,
  output logic            err,
  output logic            ovf
);
  localparam int CW = $clog2(DIGITS + 1);
  localparam int RW = $clog2(REFRESH_DIV);

  typedef enum logic {S_IDLE, S_COLLECT} state_t;
  state_t r_state, w_state_nxt;

  logic [3:0]      r_shadow [DIGITS];
  logic [CW-1:0]   r_count;
  logic            r_sh_err, r_sh_ovf;
  logic [3:0]      r_disp [DIGITS];
  logic            r_neg, r_err, r_ovf, r_ready;
  logic [RW-1:0]   r_ref;
  logic [CW-1:0]   r_idx;
  logic [DIGITS:0] r_an;
  logic [6:0]      r_seg;

  logic            w_acc, w_store, w_commit, w_wrap, w_neg_nxt, w_blank;
  logic [3:0]      w_disp_nxt [DIGITS];
  logic [3:0]      w_pos_val;
  logic [CW-1:0]   w_idx_nxt;
  logic [DIGITS:0] w_an_nxt;
  logic [6:0]      w_seg_nxt;

  function automatic logic [6:0] f_glyph(input logic [3:0] d);
    case (d)
      4'd0:    f_glyph = 7'h40;
      4'd1:    f_glyph = 7'h79;
      4'd2:    f_glyph = 7'h24;
      4'd3:    f_glyph = 7'h30;
      4'd4:    f_glyph = 7'h19;
      4'd5:    f_glyph = 7'h12;
      4'd6:    f_glyph = 7'h02;
      4'd7:    f_glyph = 7'h78;
      4'd8:    f_glyph = 7'h00;
      4'd9:    f_glyph = 7'h10;
      default: f_glyph = 7'h06;
    endcase
  endfunction

  assign w_acc    = in_valid & r_ready;
  assign w_store  = (r_count < CW'(DIGITS));
  assign w_commit = w_acc & in_last;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_acc && !in_last) w_state_nxt = S_COLLECT;
      S_COLLECT: if (w_commit) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Count only advances on a stored beat, so it saturates at DIGITS by itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) r_shadow[i] <= '0;
      r_count  <= '0;
      r_sh_err <= 1'b0;
      r_sh_ovf <= 1'b0;
    end else if (w_commit) begin
      for (int i = 0; i < DIGITS; i++) r_shadow[i] <= '0;
      r_count  <= '0;
      r_sh_err <= 1'b0;
      r_sh_ovf <= 1'b0;
    end else if (w_acc) begin
      if (w_store) begin
        for (int i = 0; i < DIGITS; i++)
          if (r_count == CW'(i)) r_shadow[i] <= diff;
        r_count  <= r_count + 1'b1;
        r_sh_err <= r_sh_err | (diff > 4'd9);
      end else begin
        r_sh_ovf <= 1'b1;
      end
    end
  end

  always_comb begin
    w_neg_nxt = r_neg;
    for (int i = 0; i < DIGITS; i++) w_disp_nxt[i] = r_disp[i];
    if (w_commit) begin
      w_neg_nxt = ~cout;
      for (int i = 0; i < DIGITS; i++)
        w_disp_nxt[i] = (w_store && r_count == CW'(i)) ? diff : r_shadow[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) r_disp[i] <= '0;
      r_neg <= 1'b0;
      r_err <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      for (int i = 0; i < DIGITS; i++) r_disp[i] <= w_disp_nxt[i];
      r_neg <= w_neg_nxt;
      if (w_commit) begin
        r_err <= r_sh_err | (w_store & (diff > 4'd9));
        r_ovf <= r_sh_ovf | ~w_store;
      end
    end
  end

  // Scan uses next-state data so a commit and a position change land on the same edge.
  assign w_wrap = r_ready && (r_ref == RW'(REFRESH_DIV - 1));

  always_comb begin
    w_idx_nxt = r_idx;
    if (w_wrap) w_idx_nxt = (r_idx == CW'(DIGITS)) ? '0 : r_idx + 1'b1;
  end

  always_comb begin
    logic v_hi_zero;
    v_hi_zero = 1'b1;
    w_pos_val = '0;
    w_blank   = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      v_hi_zero = v_hi_zero & (w_disp_nxt[i] == 4'd0);
      if (w_idx_nxt == CW'(i)) begin
        w_pos_val = w_disp_nxt[i];
`ifdef BCD_DISP_LZB_EN
        w_blank = v_hi_zero && (i != 0);
`else
        w_blank = 1'b0;
`endif
      end
    end
    for (int i = 0; i <= DIGITS; i++) w_an_nxt[i] = (w_idx_nxt != CW'(i));
    if (w_idx_nxt == CW'(DIGITS)) w_seg_nxt = w_neg_nxt ? 7'h3F : 7'h7F;
    else if (w_blank)             w_seg_nxt = 7'h7F;
    else                          w_seg_nxt = f_glyph(w_pos_val);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b0;
      r_ref   <= '0;
      r_idx   <= '0;
      r_an    <= '1;
      r_seg   <= 7'h7F;
    end else begin
      r_ready <= 1'b1;
      r_ref   <= (!r_ready || w_wrap) ? '0 : r_ref + 1'b1;
      r_idx   <= w_idx_nxt;
      r_an    <= w_an_nxt;
      r_seg   <= w_seg_nxt;
    end
  end

  assign in_ready = r_ready;
  assign an       = r_an;
  assign seg      = r_seg;
  assign neg      = r_neg;
  assign err      = r_err;
  assign ovf      = r_ovf;
endmodule

// File: tb/tb_bcd_diff_display.sv
// Self-checking bench for bcd_diff_display: random BCD results checked every cycle against a result-level model.
module tb_bcd_diff_display;
  localparam int D = 4;
  localparam int R = 4;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       in_valid = 1'b0, cout = 1'b0, in_last = 1'b0;
  logic [3:0] diff = 4'd0;
  logic       in_ready, neg, err, ovf;
  logic [D:0] an;
  logic [6:0] seg;
  int n_chk = 0, n_fail = 0;

  bcd_diff_display #(.DIGITS(D), .REFRESH_DIV(R)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .diff(diff), .cout(cout), .in_last(in_last),
    .an(an), .seg(seg), .neg(neg), .err(err), .ovf(ovf));

  always #5 clk = ~clk;

  // Result-level model: beats queue up, the last beat commits the whole number.
  int m_k;
  int m_val [D];
  bit m_neg, m_err, m_ovf;
  int m_q [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k = 0;
      foreach (m_val[i]) m_val[i] = 0;
      m_neg = 0; m_err = 0; m_ovf = 0;
      m_q.delete();
    end else begin
      if (in_valid && m_k > 0) begin
        m_q.push_back(int'(diff));
        if (in_last) begin
          m_err = 0;
          for (int i = 0; i < D; i++) begin
            m_val[i] = (i < m_q.size()) ? m_q[i] : 0;
            if (i < m_q.size() && m_q[i] > 9) m_err = 1;
          end
          m_ovf = (m_q.size() > D);
          m_neg = !cout;
          m_q.delete();
        end
      end
      m_k++;
    end
  end

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30; 4: return 7'h19;
      5: return 7'h12; 6: return 7'h02; 7: return 7'h78; 8: return 7'h00; 9: return 7'h10;
      default: return 7'h06;
    endcase
  endfunction

  function automatic int cur_pos();
    return ((m_k - 1) / R) % (D + 1);
  endfunction

  function automatic logic [D:0] exp_an();
    logic [D:0] r;
    r = '1;
    if (m_k > 0) r[cur_pos()] = 1'b0;
    return r;
  endfunction

  function automatic logic [6:0] exp_seg();
    int p, hi;
    if (m_k == 0) return 7'h7F;
    p = cur_pos();
    if (p == D) return m_neg ? 7'h3F : 7'h7F;
`ifdef BCD_DISP_LZB_EN
    hi = 0;
    for (int i = p; i < D; i++) hi += m_val[i];
    if (p > 0 && hi == 0) return 7'h7F;
`else
    hi = 0;
`endif
    return glyph(m_val[p]);
  endfunction

  function automatic int rnd_digit();
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(10, 15));
    return int'($urandom_range(0, 9));
  endfunction

  task automatic send_beat(input int d, input bit l, input bit c);
    in_valid = 1'b1; diff = 4'(d); in_last = l; cout = c;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    diff = 4'($urandom_range(0, 15)); cout = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (an !== '1 || seg !== 7'h7F) begin
      n_fail++; $display("FAIL reset_outputs: got an=%b seg=%h want an=11111 seg=7f", an, seg);
    end
    n_chk++;
    if ({in_ready, neg, err, ovf} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got ready/neg/err/ovf=%b want 0000", {in_ready, neg, err, ovf});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 2 * (D + 1) * R; c++) begin
      @(negedge clk);
      n_chk++;
      if (an !== exp_an()) begin n_fail++; $display("FAIL reset_scan_an: got %b want %b", an, exp_an()); end
      n_chk++;
      if (seg !== exp_seg()) begin n_fail++; $display("FAIL reset_scan_seg: got %h want %h", seg, exp_seg()); end
      n_chk++;
      if ({in_ready, neg, err, ovf} !== {m_k > 0, m_neg, m_err, m_ovf}) begin
        n_fail++; $display("FAIL reset_scan_flags: got %b want %b", {in_ready, neg, err, ovf}, {m_k > 0, m_neg, m_err, m_ovf});
      end
    end
  endtask

  task automatic test_commit();
    int n;
    for (int r = 0; r < 8; r++) begin
      case (r)
        0: begin send_beat(7, 0, 1); send_beat(3, 0, 1); send_beat(1, 1, 1); end
        1: send_beat(5, 1, 0);
        default: begin
          n = int'($urandom_range(1, D));
          for (int b = 0; b < n; b++) send_beat(rnd_digit(), b == n - 1, 1'($urandom_range(0, 1)));
        end
      endcase
      for (int c = 0; c < (D + 1) * R; c++) begin
        @(negedge clk);
        n_chk++;
        if (an !== exp_an()) begin n_fail++; $display("FAIL commit_an: got %b want %b", an, exp_an()); end
        n_chk++;
        if (seg !== exp_seg()) begin n_fail++; $display("FAIL commit_seg: got %h want %h (an %b)", seg, exp_seg(), an); end
        n_chk++;
        if ({neg, err, ovf} !== {m_neg, m_err, m_ovf}) begin
          n_fail++; $display("FAIL commit_flags: got neg/err/ovf=%b want %b", {neg, err, ovf}, {m_neg, m_err, m_ovf});
        end
      end
    end
  endtask

  task automatic test_overflow();
    for (int b = 1; b <= 6; b++) send_beat(b, b == 6, 1'b0);
    n_chk++;
    if (ovf !== 1'b1 || neg !== 1'b1) begin
      n_fail++; $display("FAIL overflow_flags: got ovf=%b neg=%b want ovf=1 neg=1", ovf, neg);
    end
    for (int c = 0; c < (D + 1) * R; c++) begin
      @(negedge clk);
      n_chk++;
      if (an !== exp_an()) begin n_fail++; $display("FAIL overflow_an: got %b want %b", an, exp_an()); end
      n_chk++;
      if (seg !== exp_seg()) begin n_fail++; $display("FAIL overflow_seg: got %h want %h (an %b)", seg, exp_seg(), an); end
      n_chk++;
      if ({neg, err, ovf} !== {m_neg, m_err, m_ovf}) begin
        n_fail++; $display("FAIL overflow_model_flags: got %b want %b", {neg, err, ovf}, {m_neg, m_err, m_ovf});
      end
    end
  endtask

  task automatic test_err();
    for (int r = 0; r < 2; r++) begin
      if (r == 0) begin send_beat(4, 0, 1); send_beat(12, 1, 1); end
      else        begin send_beat(8, 0, 1); send_beat(2, 1, 1); end
      n_chk++;
      if (err !== (r == 0)) begin n_fail++; $display("FAIL err_flag: got %b want %b", err, r == 0); end
      for (int c = 0; c < (D + 1) * R; c++) begin
        @(negedge clk);
        n_chk++;
        if (an !== exp_an()) begin n_fail++; $display("FAIL err_an: got %b want %b", an, exp_an()); end
        n_chk++;
        if (seg !== exp_seg()) begin n_fail++; $display("FAIL err_seg: got %h want %h (an %b)", seg, exp_seg(), an); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] beats [$];
    int n;
    for (int r = 0; r < 24; r++) begin
      n = int'($urandom_range(1, D + 2));
      for (int b = 0; b < n; b++)
        beats.push_back({1'($urandom_range(0, 1)), b == n - 1, 4'(rnd_digit())});
    end
    foreach (beats[i]) begin
      in_valid = 1'b1; diff = beats[i][3:0]; in_last = beats[i][4]; cout = beats[i][5];
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      n_chk++;
      if (an !== exp_an()) begin n_fail++; $display("FAIL b2b_an: got %b want %b", an, exp_an()); end
      n_chk++;
      if (seg !== exp_seg()) begin n_fail++; $display("FAIL b2b_seg: got %h want %h (an %b)", seg, exp_seg(), an); end
      n_chk++;
      if ({in_ready, neg, err, ovf} !== {m_k > 0, m_neg, m_err, m_ovf}) begin
        n_fail++; $display("FAIL b2b_flags: got %b want %b", {in_ready, neg, err, ovf}, {m_k > 0, m_neg, m_err, m_ovf});
      end
      if ($urandom_range(0, 3) == 0) begin
        diff = 4'($urandom_range(0, 15)); in_last = 1'($urandom_range(0, 1));
        @(negedge clk);
        in_last = 1'b0;
        n_chk++;
        if (seg !== exp_seg()) begin n_fail++; $display("FAIL b2b_idle_seg: got %h want %h", seg, exp_seg()); end
      end
    end
  endtask

  task automatic test_reset_mid();
    send_beat(3, 1, 0);
    send_beat(6, 0, 1);
    send_beat(2, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (an !== '1 || seg !== 7'h7F || neg !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_async: got an=%b seg=%h neg=%b want 11111 7f 0", an, seg, neg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 2; r++) begin
      if (r == 1) send_beat(9, 1, 1);
      for (int c = 0; c < (D + 1) * R; c++) begin
        @(negedge clk);
        n_chk++;
        if (an !== exp_an()) begin n_fail++; $display("FAIL reset_mid_an: got %b want %b", an, exp_an()); end
        n_chk++;
        if (seg !== exp_seg()) begin n_fail++; $display("FAIL reset_mid_seg: got %h want %h (an %b)", seg, exp_seg(), an); end
        n_chk++;
        if ({neg, err, ovf} !== {m_neg, m_err, m_ovf}) begin
          n_fail++; $display("FAIL reset_mid_flags: got %b want %b", {neg, err, ovf}, {m_neg, m_err, m_ovf});
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_commit();
    test_overflow();
    test_err();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_diff_display.md
Name: bcd_diff_display

Overview:
- Downstream stage of the BCD subtractor chain. Collects the digit-serial difference (LSD first) plus the final borrow/sign bit.
- Holds the committed multi-digit result and drives a time-multiplexed, active-low seven-segment display.
- Layout: one sign position plus DIGITS digit positions.
- Reports sign, invalid-digit and overflow status to the rest of the lab design.

Parameters:
- DIGITS, 4, number of BCD digit positions shown (sign position is extra); range 1..8.
- REFRESH_DIV, 50000, clock cycles each display position stays lit; range ≥2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  digit beat present on diff/cout/in_last.
- in_ready  out  1  block accepts a beat this cycle.
- diff  in  4  BCD difference digit from subtractor stage.
- cout  in  1  subtractor carry: 1 = result non-negative, 0 = negative. Sampled only on the in_last beat.
- in_last  in  1  marks the most significant (final) digit of a result.
- an  out  DIGITS+1  active-low position enables, one-hot-low. Bit DIGITS is the sign position; bit 0 is the LSD.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}.
- neg  out  1  committed result is negative.
- err  out  1  committed result contained a digit >9.
- ovf  out  1  committed result had more than DIGITS beats.

Behaviour:
- Reset (async, rst_n=0):
  - Shadow and display registers cleared to 0; beat counter = 0.
  - neg = err = ovf = 0; in_ready = 0.
  - Refresh counter = 0; scan index = 0; an = all 1s; seg = 7'h7F (blank).
- First rising clk after rst_n deasserts: in_ready = 1, scan starts at index 0.
- Capture FSM, states IDLE and COLLECT:
  - IDLE: in_ready = 1. An accepted beat (in_valid & in_ready) writes diff into shadow digit 0 and sets the beat count to 1.
  - If that beat has in_last = 0, go to COLLECT. If in_last = 1, commit and stay in IDLE.
  - COLLECT: in_ready = 1. Each accepted beat writes shadow digit[count] while count < DIGITS; otherwise the digit is dropped and the shadow ovf flag is set. Count saturates at DIGITS.
  - in_last beat in COLLECT: commit, return to IDLE.
  - Cycles with in_valid = 0 cause no change in any state.
- Commit, taking effect on the clock edge that accepts the in_last beat:
  - Display digits take the shadow digits, with the in_last digit included in the same edge.
  - Positions not written in this result are forced to 0.
  - neg = ~cout of the in_last beat.
  - err = OR of (digit > 9) over accepted, stored digits of this result.
  - ovf = shadow ovf flag.
  - Shadow and count are cleared afterwards.
  - The previous result stays displayed until the commit edge; there is no partial update.
- Display scan:
  - Refresh counter counts 0..REFRESH_DIV-1 and wraps. On wrap, scan index advances 0→1→…→DIGITS→0.
  - an has a single 0 at bit [scan index].
  - Digit positions use active-low glyphs: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10. Any value >9 shows 'E' = 06.
  - Sign position shows 3F (minus) when neg = 1, else 7F (blank).
  - an and seg are registered and change together on the same edge; there are no glitch cycles between positions.
- Simultaneous events:
  - A commit on the same edge as a scan advance: the new position shows the new data immediately.
  - Reset mid-COLLECT discards the shadow; the displayed result is cleared to 0 with neg = 0.

Optional Feature:
- Macro: BCD_DISP_LZB_EN.
- Defined: leading-zero blanking on digit positions DIGITS-1 down to 1. Any position whose value and all higher digit values are 0 shows 7F.
  - LSD position 0 is never blanked.
  - The minus sign stays at position DIGITS; it does not float.
  - Digits >9 count as non-zero.
- Undefined: all digit positions always show their glyph, including leading 0s.

Test Plan:
- Reset release, REFRESH_DIV=4, DIGITS=4, no beats:
  - an cycles 11110→11101→11011→10111→01111, 4 clk each.
  - Digit positions show seg=40; sign position shows 7F; neg = err = ovf = 0.
- Beats 7, 3, 1 (last, cout=1) → committed 0137.
  - Position 0 shows 78, position 1 shows 30, position 2 shows 79, position 3 shows 40 (7F with BCD_DISP_LZB_EN); neg = 0.
- Single beat diff=5, in_last=1, cout=0 → position 0 shows 12, sign position shows 3F, neg = 1, all upper digits 0.
- Six beats 1..6 (6 last) → display 4321, ovf = 1; beats 5 and 6 dropped; sign from beat 6's cout.
- Beats 4, 12 (last, cout=1) → position 1 shows 06 ('E'), err = 1. The next valid result clears err.
- rst_n pulled low after 2 of 3 beats → an = all 1s and seg = 7F immediately (async). After release, the display shows 0 and the earlier beats never commit.
